pow_n_en_pipe_bp: RTL and testbench

//  Pipelined integer power unit: res = arg**N, full precision, one multiplier per stage.

---
 rtl/pow_pkg.sv | 16 +
 rtl/pow_n_en_pipe_bp_if.sv | 25 ++
 rtl/pow_n_stage.sv | 40 ++++
 rtl/pow_n_en_pipe_bp.sv | 62 ++++++
 tb/tb_pow_n_en_pipe_bp.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pow_pkg.sv
// Shared constants and helpers for the pipelined integer power unit.
package pow_pkg;

    localparam int unsigned POW_N_MIN = 2;
    localparam int unsigned POW_N_MAX = 8;

    // Width of the product held in stage k (a**(k+1) for a W-bit argument).
    function automatic int unsigned stage_w(input int unsigned w, input int unsigned k);
        return w * (k + 1);
    endfunction

    function automatic bit n_legal(input int unsigned n);
        return (n >= POW_N_MIN) && (n <= POW_N_MAX);
    endfunction

endpackage

// File: rtl/pow_n_en_pipe_bp_if.sv
// Argument/result handshake bundle for the power pipeline, plus stage occupancy.
interface pow_n_en_pipe_bp_if #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 5
);
    localparam int unsigned RW = W * N;

    logic          arg_vld;
    logic          arg_rdy;
    logic [W-1:0]  arg;
    logic          res_vld;
    logic          res_rdy;
    logic [RW-1:0] res;
    logic [N-2:0]  stage_vld;

    modport master (
        output arg_vld, arg, res_rdy,
        input  arg_rdy, res_vld, res, stage_vld
    );

    modport slave (
        input  arg_vld, arg, res_rdy,
        output arg_rdy, res_vld, res, stage_vld
    );
endinterface

// File: rtl/pow_n_stage.sv
// One pipeline stage: multiplies the incoming partial power by the argument copy.
module pow_n_stage
    import pow_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned K = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       adv,
    input  logic                       in_vld,
    input  logic [W-1:0]               in_a,
    input  logic [W*K-1:0]             in_p,
    output logic                       vld,
    output logic [W-1:0]               a,
    output logic [stage_w(W, K)-1:0]   p
);
    localparam int unsigned PW = stage_w(W, K);

    logic [PW-1:0] prod_c;

    // Full-precision product: operands widened so nothing is truncated.
    assign prod_c = PW'(in_p) * PW'(in_a);

    // Valid follows upstream on advance; data only captured from a valid upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            a   <= '0;
            p   <= '0;
        end else if (adv) begin
            vld <= in_vld;
            if (in_vld) begin
                a <= in_a;
                p <= prod_c;
            end
        end
    end

endmodule

// File: rtl/pow_n_en_pipe_bp.sv
// Pipelined res = arg**N with ready/valid back-pressure and a global clock enable.
module pow_n_en_pipe_bp
    import pow_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    pow_n_en_pipe_bp_if.slave bus
);
    localparam int unsigned RW = W * N;

    if (!n_legal(N)) begin : g_bad_n
        $error("pow_n_en_pipe_bp: N must lie in 2..8");
    end

    // Index 0 is the input side; index k is the output of stage k.
    logic [N-1:0]  v;
    logic [N-1:1]  adv;
    logic [W-1:0]  a_chain [N];
    logic [RW-1:0] p_chain [N];

    assign v[0]       = bus.arg_vld;
    assign a_chain[0] = bus.arg;
    assign p_chain[0] = RW'(bus.arg);

    // A stage may move when some stage at or after it is empty, or the sink takes the result.
    for (genvar k = 1; k < N; k++) begin : g_adv
        assign adv[k] = clk_en & (bus.res_rdy | ~(&v[N-1:k]));
    end

    for (genvar k = 1; k < N; k++) begin : g_stg
        localparam int unsigned PW = stage_w(W, k);

        logic [PW-1:0] p;

        pow_n_stage #(
            .W (W),
            .K (k)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .adv    (adv[k]),
            .in_vld (v[k-1]),
            .in_a   (a_chain[k-1]),
            .in_p   (p_chain[k-1][W*k-1:0]),
            .vld    (v[k]),
            .a      (a_chain[k]),
            .p      (p)
        );

        assign p_chain[k] = RW'(p);
    end

    assign bus.arg_rdy   = adv[1];
    assign bus.res_vld   = v[N-1];
    assign bus.res       = p_chain[N-1];
    assign bus.stage_vld = v[N-1:1];

endmodule

// File: tb/tb_pow_n_en_pipe_bp.sv
// Directed bench for the power pipeline: queue-based model plus pinned literal results.
module tb_pow_n_en_pipe_bp;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pow_n_en_pipe_bp_if #(.W(8), .N(5)) b5 ();
    pow_n_en_pipe_bp_if #(.W(4), .N(2)) b2 ();

    pow_n_en_pipe_bp #(.W(8), .N(5)) dut5 (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (b5)
    );

    pow_n_en_pipe_bp #(.W(4), .N(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (b2)
    );

    logic [63:0] q5[$];
    logic [63:0] q2[$];
    logic [63:0] got5[$];
    logic [63:0] got2[$];
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ipow(input int unsigned a, input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < int'(n); i++) r = r * 64'(a);
        return r;
    endfunction

    task automatic check_list(input string name, input logic [63:0] got[$], input logic [63:0] exp[$]);
        check({name, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", name, i), got[i], exp[i]);
    endtask

    // Model: every accepted argument is owed arg**N, in order; occupancy equals items owed.
    always @(negedge clk) begin
        if (rst) begin
            q5.delete();
            q2.delete();
            check("rst_res_vld5",   64'(b5.res_vld),   64'd0);
            check("rst_res5",       64'(b5.res),       64'd0);
            check("rst_stage_vld5", 64'(b5.stage_vld), 64'd0);
            check("rst_arg_rdy5",   64'(b5.arg_rdy),   64'(clk_en));
            check("rst_res_vld2",   64'(b5.res_vld),   64'd0);
            check("rst_stage_vld2", 64'(b2.stage_vld), 64'd0);
            check("rst_arg_rdy2",   64'(b2.arg_rdy),   64'(clk_en));
        end else begin
            check("arg_rdy5", 64'(b5.arg_rdy), 64'(clk_en & ((q5.size() < 4) | b5.res_rdy)));
            check("occ5", 64'($countones(b5.stage_vld)), 64'(q5.size()));
            if (b5.res_vld) begin
                if (q5.size() == 0) check("spurious5", 64'd1, 64'd0);
                else check("res5", 64'(b5.res), q5[0]);
                if (b5.res_rdy && clk_en) begin
                    got5.push_back(64'(b5.res));
                    if (q5.size() != 0) void'(q5.pop_front());
                end
            end
            if (b5.arg_vld && b5.arg_rdy) q5.push_back(ipow(b5.arg, 5));

            check("arg_rdy2", 64'(b2.arg_rdy), 64'(clk_en & ((q2.size() < 1) | b2.res_rdy)));
            check("occ2", 64'($countones(b2.stage_vld)), 64'(q2.size()));
            if (b2.res_vld) begin
                if (q2.size() == 0) check("spurious2", 64'd1, 64'd0);
                else check("res2", 64'(b2.res), q2[0]);
                if (b2.res_rdy && clk_en) begin
                    got2.push_back(64'(b2.res));
                    if (q2.size() != 0) void'(q2.pop_front());
                end
            end
            if (b2.arg_vld && b2.arg_rdy) q2.push_back(ipow(b2.arg, 2));
        end
    end

    task automatic send5(input logic [7:0] x);
        bit ok;
        ok = 1'b0;
        b5.arg = x;
        b5.arg_vld = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b5.arg_rdy;
            @(posedge clk);
            #1;
        end
        b5.arg_vld = 1'b0;
        check("send5_accept", 64'(ok), 64'd1);
    endtask

    task automatic send2(input logic [3:0] x);
        bit ok;
        ok = 1'b0;
        b2.arg = x;
        b2.arg_vld = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b2.arg_rdy;
            @(posedge clk);
            #1;
        end
        b2.arg_vld = 1'b0;
        check("send2_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain(input string name);
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(negedge clk);
            empty = (q5.size() == 0) && (q2.size() == 0);
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, 64'(empty), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit done;
        rst = 1'b1;
        clk_en = 1'b1;
        b5.arg_vld = 1'b0; b5.arg = '0; b5.res_rdy = 1'b1;
        b2.arg_vld = 1'b0; b2.arg = '0; b2.res_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single pulse: result exactly four cycles later, one cycle wide.
        got5.delete();
        b5.arg = 8'd3;
        b5.arg_vld = 1'b1;
        @(posedge clk);
        #1 b5.arg_vld = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("s1_vld_%0d", c), 64'(b5.res_vld), 64'(c == 4));
            if (c == 4) check("s1_res", 64'(b5.res), 64'd243);
            @(posedge clk);
            #1;
        end

        // Extremes of the argument range.
        got5.delete();
        send5(8'd255);
        send5(8'd0);
        send5(8'd1);
        drain("s2");
        exp_q.delete();
        exp_q.push_back(64'd1078203909375);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        check_list("s2", got5, exp_q);

        // Stalled sink: four accepted, then back-pressure; full-pipe accept-and-emit.
        got5.delete();
        b5.res_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send5(8'(i));
        b5.arg = 8'd5;
        b5.arg_vld = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("s3_full_rdy0",  64'(b5.arg_rdy),   64'd0);
            check("s3_full_stage", 64'(b5.stage_vld), 64'hF);
            check("s3_hold_res",   64'(b5.res),       64'd1);
            @(posedge clk);
            #1;
        end
        b5.res_rdy = 1'b1;
        @(negedge clk);
        check("s3_full_rdy1", 64'(b5.arg_rdy), 64'd1);
        @(posedge clk);
        #1 b5.arg_vld = 1'b0;
        send5(8'd6);
        drain("s3");
        exp_q.delete();
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd32);
        exp_q.push_back(64'd243);
        exp_q.push_back(64'd1024);
        exp_q.push_back(64'd3125);
        exp_q.push_back(64'd7776);
        check_list("s3", got5, exp_q);

        // Enable one cycle in four: four enabled edges to the result, frozen in between.
        got5.delete();
        b5.arg = 8'd2;
        b5.arg_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            clk_en = (c % 4 == 0);
            @(negedge clk);
            if (c == 2)  check("s4_stage_2", 64'(b5.stage_vld), 64'h1);
            if (c == 12) check("s4_vld_12",  64'(b5.res_vld),   64'd0);
            if (c == 13) begin
                check("s4_vld_13", 64'(b5.res_vld), 64'd1);
                check("s4_res_13", 64'(b5.res),     64'd32);
            end
            @(posedge clk);
            #1;
            if (c == 0) b5.arg_vld = 1'b0;
        end
        clk_en = 1'b1;
        drain("s4");
        exp_q.delete();
        exp_q.push_back(64'd32);
        check_list("s4", got5, exp_q);

        // Reset with items in flight: everything discarded at once.
        got5.delete();
        send5(8'd7);
        send5(8'd8);
        send5(8'd9);
        rst = 1'b1;
        #1;
        check("s5_res_vld",   64'(b5.res_vld),   64'd0);
        check("s5_stage_vld", 64'(b5.stage_vld), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send5(8'd4);
        drain("s5");
        exp_q.delete();
        exp_q.push_back(64'd1024);
        check_list("s5", got5, exp_q);

        // Single-stage configuration.
        got2.delete();
        b2.res_rdy = 1'b1;
        send2(4'd15);
        @(negedge clk);
        check("s6_vld", 64'(b2.res_vld), 64'd1);
        check("s6_res", 64'(b2.res),     64'd225);
        @(posedge clk);
        #1;
        drain("s6a");

        got2.delete();
        done = 1'b0;
        fork
            begin
                for (int x = 0; x < 16; x++) send2(4'(x));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    b2.res_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        b2.res_rdy = 1'b1;
        drain("s6b");
        exp_q.delete();
        for (int x = 0; x < 16; x++) exp_q.push_back(ipow(x, 2));
        check_list("s6", got2, exp_q);
        check("s6_last_literal", got2.size() == 16 ? got2[15] : 64'd0, 64'd225);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
